mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one memory port between instruction fetch (imem) and load/store (dmem) requesters.
- Sits between the fetch stage and memory stage on one side and the single memory/cache port on the other.
- One transaction outstanding at a time.
- dmem has priority, bounded by an anti-starvation limit.
- A fetch squash (branch mispredict) discards the response of an in-flight fetch, so the fetch stage can re-request immediately.

Parameters:
STARVE_LIMIT, 4, consecutive dmem grants allowed while imem waits before imem is forced next (must be >= 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_addr  in  32  fetch address, held stable until imem_resp
imem_rmask  in  4  nonzero = fetch request pending (level, held until imem_resp)
imem_rdata  out  32  fetch data, valid with imem_resp
imem_resp  out  1  fetch complete, one cycle
dmem_addr  in  32  load/store address, held until dmem_resp
dmem_rmask  in  4  load byte mask
dmem_wmask  in  4  store byte mask; request pending = (rmask|wmask) != 0
dmem_wdata  in  32  store data
dmem_rdata  out  32  load data, valid with dmem_resp
dmem_resp  out  1  load/store complete, one cycle
fetch_squash  in  1  mispredict: discard the in-flight fetch response
mem_addr  out  32  memory address, registered, held for the whole transaction
mem_rmask  out  4  registered, asserted for exactly the issue cycle
mem_wmask  out  4  registered, asserted for exactly the issue cycle
mem_wdata  out  32  registered, held for the whole transaction
mem_rdata  in  32  memory read data
mem_resp  in  1  memory transaction done

Behaviour:
- Reset: state IDLE; starve_cnt=0; squashed=0; all mem_* outputs 0; imem_resp=dmem_resp=0.
- FSM states are IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D.
- IDLE: sample requests at the clock edge.
  - dmem pending and (imem idle or starve_cnt<STARVE_LIMIT): go to ISSUE_D, starve_cnt += (imem pending ? 1 : 0), saturating.
  - Otherwise, imem pending: go to ISSUE_I, starve_cnt=0.
  - Neither pending: stay in IDLE.
- ISSUE_x: drive the mem_* registers from the latched request.
  - ISSUE_I: rmask=imem_rmask, wmask=0.
  - ISSUE_D: both masks and wdata from dmem.
  - Masks are nonzero for this cycle only; addr/wdata are held until mem_resp.
  - Next state is WAIT_x unconditionally. mem_resp in an ISSUE cycle is ignored: memory latency is >= 1 cycle after the issue cycle.
- WAIT_x: on mem_resp, go to IDLE.
- Timing: request sampled in IDLE at edge t, issue in cycle t+1, earliest mem_resp in cycle t+2.
- Back-to-back: mem_resp at cycle r, IDLE at r+1, next issue at r+2.
- Responses: combinational passthrough.
  - dmem_resp = mem_resp & WAIT_D.
  - imem_resp = mem_resp & WAIT_I & ~squashed & ~fetch_squash.
  - imem_rdata = dmem_rdata = mem_rdata.
- Squash:
  - fetch_squash in ISSUE_I or WAIT_I sets squashed=1.
  - A squashed fetch still completes on the memory side, but imem_resp is suppressed.
  - squashed clears on the exit to IDLE.
  - fetch_squash in IDLE or a D state has no effect.
  - fetch_squash in the same cycle as mem_resp in WAIT_I drops that response.
- A squashed fetch counts as an imem grant for starvation purposes (starve_cnt was already cleared at grant).
- dmem with both rmask and wmask nonzero: both are forwarded unchanged; no arbiter error.
- Reset mid-transaction:
  - The FSM returns to IDLE and the outstanding transaction is abandoned.
  - A later stray mem_resp while IDLE produces no client response.
  - Memory must be reset with the core.
- Requester address/mask changes while pending violate the protocol; the arbiter uses the value latched at grant.

Decomposition:
- Shared package rv32i_types:
  - arb_state_t enum: IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D.
  - mem_req_t struct: addr, rmask, wmask, wdata.
- Single module; no sub-module needed. The starvation counter is inline, width $clog2(STARVE_LIMIT+1).

Test Plan:
1. imem-only fetch:
   - Stimulus: imem_rmask=4'hF, addr=0x6000_0000; memory responds 2 cycles after issue with rdata=0x0000_0013.
   - Required: mem_rmask=4'hF for exactly 1 cycle; imem_resp=1 with rdata 0x13; dmem_resp never asserts.
2. Simultaneous requests:
   - Stimulus: imem and dmem (store, wmask=4'h3, addr=0x100, wdata=0xBEEF) raised in the same cycle.
   - Required: dmem is issued first (mem_wmask=4'h3, mem_rmask=0); imem is issued at the second cycle after the dmem mem_resp.
3. Starvation:
   - Stimulus: dmem held continuously pending with imem pending, STARVE_LIMIT=4.
   - Required: grant order D,D,D,D,I,D…; exactly one imem grant after 4 dmem grants.
4. Squash mid-fetch:
   - Stimulus: fetch_squash pulses 1 cycle after fetch issue; mem_resp arrives later; fetch stage re-requests addr 0x6000_0040.
   - Required: no imem_resp for the first fetch; the second fetch issues after the first mem_resp and returns normally.
5. Squash coincident with response:
   - Stimulus: fetch_squash and mem_resp asserted in the same WAIT_I cycle.
   - Required: imem_resp=0; next cycle state is IDLE.
6. Reset mid-transaction:
   - Stimulus: rst asserted in WAIT_D; mem_resp arrives 1 cycle after rst deasserts.
   - Required: all outputs 0 during and after reset; no dmem_resp or imem_resp generated.

Source files
------------

// File: rtl/rv32i_types.sv
// Types shared between the memory-port arbiter and the blocks that talk to it.
package rv32i_types;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_I = 3'd1,
    ISSUE_D = 3'd2,
    WAIT_I  = 3'd3,
    WAIT_D  = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (imem) and load/store (dmem), one
// transaction at a time, dmem first but with a bound on how long fetch waits.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; requests sampled at the clock edge
// ISSUE_I | fetch masks on the memory port for this cycle only
// ISSUE_D | load/store masks on the memory port for this cycle only
// WAIT_I  | fetch outstanding; mem_resp returns to IDLE
// WAIT_D  | load/store outstanding; mem_resp returns to IDLE
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  input  logic        fetch_squash,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_t    state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          squashed;
  logic          i_pend, d_pend, pick_d;
  mem_req_t      grant_req, req_q;

  assign i_pend = |imem_rmask;
  assign d_pend = |(dmem_rmask | dmem_wmask);
  // dmem wins unless fetch has already waited through LIMIT dmem grants
  assign pick_d = d_pend & (~i_pend | (starve_cnt < LIMIT));

  always_comb begin
    grant_req = '0;
    if (pick_d) begin
      grant_req.addr  = dmem_addr;
      grant_req.rmask = dmem_rmask;
      grant_req.wmask = dmem_wmask;
      grant_req.wdata = dmem_wdata;
    end else begin
      grant_req.addr  = imem_addr;
      grant_req.rmask = imem_rmask;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_d)      state_nxt = ISSUE_D;
        else if (i_pend) state_nxt = ISSUE_I;
      end
      ISSUE_I: state_nxt = WAIT_I;
      ISSUE_D: state_nxt = WAIT_D;
      WAIT_I, WAIT_D: begin
        if (mem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      squashed   <= 1'b0;
      req_q      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_d) begin
            req_q <= grant_req;
            if (i_pend && (starve_cnt != LIMIT)) starve_cnt <= starve_cnt + CW'(1);
          end else if (i_pend) begin
            req_q      <= grant_req;
            starve_cnt <= '0;
          end
        end
        ISSUE_I: begin
          req_q.rmask <= '0;
          req_q.wmask <= '0;
          if (fetch_squash) squashed <= 1'b1;
        end
        ISSUE_D: begin
          req_q.rmask <= '0;
          req_q.wmask <= '0;
        end
        // a squashed fetch still runs to completion on the memory side
        WAIT_I: begin
          if (mem_resp)          squashed <= 1'b0;
          else if (fetch_squash) squashed <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = req_q.addr;
  assign mem_rmask = req_q.rmask;
  assign mem_wmask = req_q.wmask;
  assign mem_wdata = req_q.wdata;

  assign dmem_resp  = mem_resp & (state == WAIT_D);
  assign imem_resp  = mem_resp & (state == WAIT_I) & ~squashed & ~fetch_squash;
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  import rv32i_types::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask, mem_rmask, mem_wmask;
  logic        imem_resp, dmem_resp, fetch_squash, mem_resp;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .fetch_squash(fetch_squash),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  int chk_cnt = 0, err_cnt = 0, cyc = 0;

  task automatic check_eq(string tag, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // reference model: who owns the port, whether this is its issue cycle
  int          owner = 0;            // 0 none, 1 fetch, 2 load/store
  bit          issue_now = 0, m_sq = 0, after_rst = 0, model_valid = 0;
  int          streak = 0;           // dmem grants while fetch waited
  logic [31:0] e_addr = '0, e_wdata = '0;
  logic [3:0]  e_rmask = '0, e_wmask = '0;

  // memory model and observations
  int          lat = 0, fixed_lat = 0;
  bit          stray = 0, fix_data_en = 0;
  logic [31:0] fix_data = '0;
  bit          obs_iresp = 0, obs_dresp = 0;
  int          issue_cyc = -1, resp_cyc = -1, dresp_cyc = -1, iresp_cnt = 0, dresp_cnt = 0, issue_cnt = 0;
  logic [31:0] last_irdata = '0, iss_addr = '0;

  task automatic model_edge();
    bit ip, dp;
    ip = (imem_rmask != 4'h0);
    dp = ((dmem_rmask | dmem_wmask) != 4'h0);
    after_rst = 0;
    if (rst) begin
      owner = 0; issue_now = 0; m_sq = 0; streak = 0; lat = 0;
      after_rst = 1; model_valid = 1;
      e_addr = '0; e_wdata = '0; e_rmask = '0; e_wmask = '0;
    end else if (owner == 0) begin
      if (dp && (!ip || streak < LIMIT)) begin
        owner = 2;
        if (ip) streak++;
        e_addr = dmem_addr; e_rmask = dmem_rmask; e_wmask = dmem_wmask; e_wdata = dmem_wdata;
      end else if (ip) begin
        owner = 1; streak = 0;
        e_addr = imem_addr; e_rmask = imem_rmask; e_wmask = 4'h0;
      end
      issue_now = (owner != 0);
    end else if (issue_now) begin
      issue_now = 0;
      if (owner == 1 && fetch_squash) m_sq = 1;
    end else if (mem_resp) begin
      owner = 0; m_sq = 0;
    end else if (owner == 1 && fetch_squash) begin
      m_sq = 1;
    end
  endtask

  task automatic step();
    bit exp_i, exp_d;
    if (lat > 0) begin
      lat--;
      mem_resp = (lat == 0);
    end else begin
      mem_resp = stray;
    end
    mem_rdata = fix_data_en ? fix_data : $urandom;
    #1;
    exp_i = (owner == 1) && !issue_now && mem_resp && !m_sq && !fetch_squash;
    exp_d = (owner == 2) && !issue_now && mem_resp;
    if (model_valid) begin
      check_eq("imem_resp", 32'(imem_resp), 32'(exp_i));
      check_eq("dmem_resp", 32'(dmem_resp), 32'(exp_d));
      if (mem_resp) begin
        check_eq("imem_rdata", imem_rdata, mem_rdata);
        check_eq("dmem_rdata", dmem_rdata, mem_rdata);
      end
    end
    obs_iresp = imem_resp;
    obs_dresp = dmem_resp;
    if (mem_resp) resp_cyc = cyc;
    if (imem_resp === 1'b1) begin iresp_cnt++; last_irdata = imem_rdata; end
    if (dmem_resp === 1'b1) begin dresp_cnt++; dresp_cyc = cyc; end
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    if (model_valid) begin
      check_eq("mem_rmask", 32'(mem_rmask), 32'(issue_now ? e_rmask : 4'h0));
      check_eq("mem_wmask", 32'(mem_wmask), 32'(issue_now ? e_wmask : 4'h0));
      if (owner != 0 || after_rst) check_eq("mem_addr", mem_addr, e_addr);
      if (owner == 2 || after_rst) check_eq("mem_wdata", mem_wdata, e_wdata);
    end
    if ((mem_rmask | mem_wmask) != 4'h0) begin
      lat = 1 + ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3)));
      issue_cyc = cyc;
      iss_addr = mem_addr;
      issue_cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_rmask = '0; dmem_rmask = '0; dmem_wmask = '0; fetch_squash = 1'b0;
    stray = 0; fixed_lat = 0; fix_data_en = 0;
    step(); step();
    rst = 1'b0;
    iresp_cnt = 0; dresp_cnt = 0; issue_cnt = 0; issue_cyc = -1; resp_cyc = -1; dresp_cyc = -1;
  endtask

  task automatic gen();
    if (fetch_squash) begin
      imem_addr = $urandom & 32'hFFFF_FFFC; imem_rmask = 4'hF;
    end else if (obs_iresp) begin
      imem_rmask = 4'h0;
    end
    if (imem_rmask == 4'h0 && $urandom_range(0, 2) == 0) begin
      imem_addr = $urandom & 32'hFFFF_FFFC; imem_rmask = 4'hF;
    end
    if (obs_dresp) begin dmem_rmask = 4'h0; dmem_wmask = 4'h0; end
    if ((dmem_rmask | dmem_wmask) == 4'h0 && $urandom_range(0, 1) == 0) begin
      dmem_addr = $urandom; dmem_wdata = $urandom;
      case ($urandom_range(0, 3))
        0: begin dmem_rmask = 4'hF; dmem_wmask = 4'h0; end
        1: begin dmem_rmask = 4'h0; dmem_wmask = 4'($urandom_range(1, 15)); end
        2: begin dmem_rmask = 4'($urandom_range(1, 15)); dmem_wmask = 4'($urandom_range(1, 15)); end
        default: begin dmem_rmask = 4'($urandom_range(1, 15)); dmem_wmask = 4'h0; end
      endcase
    end
    fetch_squash = (imem_rmask != 4'h0) && ($urandom_range(0, 7) == 0);
    rst = ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    int first_mr, mr, n_i_iss;
    bit t5_iresp, d_seen;
    int g_q[$];
    int exp_g[6] = '{2, 2, 2, 2, 1, 2};
    imem_addr = '0; dmem_addr = '0; dmem_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;

    // 1: lone fetch, memory answers two cycles after issue
    do_reset();
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_masks", 32'({mem_rmask, mem_wmask}), 32'h0);
    imem_addr = 32'h6000_0000; imem_rmask = 4'hF; fixed_lat = 2;
    fix_data_en = 1; fix_data = 32'h0000_0013;
    for (int k = 0; k < 10 && iresp_cnt == 0; k++) step();
    imem_rmask = 4'h0;
    step(); step();
    check_eq("t1_iresp_cnt", 32'(iresp_cnt), 32'd1);
    check_eq("t1_rdata", last_irdata, 32'h0000_0013);
    check_eq("t1_issue_cnt", 32'(issue_cnt), 32'd1);
    check_eq("t1_latency", 32'(resp_cyc - issue_cyc), 32'd2);
    check_eq("t1_dresp_cnt", 32'(dresp_cnt), 32'd0);

    // 2: simultaneous requests, store goes first
    do_reset();
    fixed_lat = 1; d_seen = 0; n_i_iss = -1;
    imem_addr = 32'h6000_0080; imem_rmask = 4'hF;
    dmem_addr = 32'h100; dmem_rmask = 4'h0; dmem_wmask = 4'h3; dmem_wdata = 32'hBEEF;
    for (int k = 0; k < 20 && iresp_cnt == 0; k++) begin
      step();
      if (issue_cyc == cyc && !d_seen) begin
        d_seen = 1;
        check_eq("t2_first_wmask", 32'(mem_wmask), 32'h3);
        check_eq("t2_first_rmask", 32'(mem_rmask), 32'h0);
        check_eq("t2_first_addr", mem_addr, 32'h100);
      end else if (issue_cyc == cyc && iss_addr == 32'h6000_0080) begin
        n_i_iss = cyc;
      end
      if (obs_dresp) dmem_wmask = 4'h0;
    end
    imem_rmask = 4'h0;
    step();
    check_eq("t2_i_after_d", 32'(n_i_iss - dresp_cyc), 32'd2);
    check_eq("t2_iresp_cnt", 32'(iresp_cnt), 32'd1);

    // 3: dmem always pending, fetch must get in after LIMIT dmem grants
    do_reset();
    g_q.delete();
    imem_addr = 32'h6000_0100; imem_rmask = 4'hF;
    dmem_addr = 32'h200; dmem_rmask = 4'hF; dmem_wmask = 4'h0;
    for (int k = 0; k < 100 && g_q.size() < 6; k++) begin
      step();
      if (issue_cyc == cyc) g_q.push_back((mem_addr == 32'h200) ? 2 : 1);
    end
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("t3_grant%0d", i), 32'((i < g_q.size()) ? g_q[i] : 0), 32'(exp_g[i]));

    // 4: squash one cycle after the fetch issues, then re-fetch
    do_reset();
    imem_addr = 32'h6000_0000; imem_rmask = 4'hF; fixed_lat = 3; first_mr = -1;
    for (int k = 0; k < 10 && issue_cyc != cyc; k++) step();
    step();
    fetch_squash = 1'b1;
    step();
    fetch_squash = 1'b0; imem_addr = 32'h6000_0040;
    for (int k = 0; k < 20 && iresp_cnt == 0; k++) begin
      step();
      if (first_mr < 0 && resp_cyc >= 0) first_mr = resp_cyc;
    end
    imem_rmask = 4'h0;
    step();
    check_eq("t4_iresp_cnt", 32'(iresp_cnt), 32'd1);
    check_eq("t4_refetch_addr", iss_addr, 32'h6000_0040);
    check_eq("t4_refetch_gap", 32'(issue_cyc - first_mr), 32'd2);

    // 5: squash in the same cycle as the fetch response
    do_reset();
    imem_addr = 32'h6000_0200; imem_rmask = 4'hF; fixed_lat = 2;
    for (int k = 0; k < 10 && issue_cyc != cyc; k++) step();
    step(); step();
    fetch_squash = 1'b1;
    step();
    t5_iresp = obs_iresp;
    mr = resp_cyc;
    fetch_squash = 1'b0;
    for (int k = 0; k < 10 && issue_cyc <= mr; k++) step();
    imem_rmask = 4'h0;
    check_eq("t5_iresp", 32'(t5_iresp), 32'd0);
    check_eq("t5_reissue_gap", 32'(issue_cyc - mr), 32'd2);

    // 6: reset while a load is outstanding, stray response afterwards
    do_reset();
    dmem_addr = 32'h300; dmem_rmask = 4'hF; dmem_wmask = 4'h0; fixed_lat = 4;
    for (int k = 0; k < 10 && issue_cyc != cyc; k++) step();
    step(); step();
    rst = 1'b1; dmem_rmask = 4'h0;
    step();
    check_eq("t6_rst_addr", mem_addr, 32'h0);
    check_eq("t6_rst_masks", 32'({mem_rmask, mem_wmask}), 32'h0);
    check_eq("t6_rst_wdata", mem_wdata, 32'h0);
    check_eq("t6_rst_resps", 32'({imem_resp, dmem_resp}), 32'h0);
    rst = 1'b0;
    step();
    dresp_cnt = 0; iresp_cnt = 0;
    stray = 1;
    step();
    stray = 0;
    step();
    check_eq("t6_stray_dresp", 32'(dresp_cnt), 32'd0);
    check_eq("t6_stray_iresp", 32'(iresp_cnt), 32'd0);

    // random traffic against the model
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      gen();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
